alarm_bank_ctrl: RTL and testbench

- Parametrised multi-alarm controller for the digital clock; successor to the single-alarm on/off/hour/minute edit FSM.
- Holds NUM_ALM alarm entries (enable, hour, minute), edited with the two function switches (F1 and F2).
- Compares the enabled entries against current time once per minute and drives ringing.
- Supports snooze (limited count) and ring auto-timeout; sits between the switch debouncers, the timekeeping counter and the display/buzzer mux.

---
 rtl/alarm_bank_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alarm_bank_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank_ctrl.sv
// alarm_bank_ctrl
// Multi-entry alarm controller: two-switch editor for NUM_ALM alarm entries,
// once-per-minute comparison against the current time, and a ring/snooze
// sequencer with a limited snooze count and an unanswered-ring timeout.
// Every output is a decode of registered state, so there is no combinational
// path from the switch inputs to the display/buzzer side.
module alarm_bank_ctrl #(
    parameter int NUM_ALM          = 2,
    parameter int IDXW             = (NUM_ALM > 1) ? $clog2(NUM_ALM) : 1,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_MIN = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SW_F1,
    input  logic               SW_F2,
    input  logic               MIN_TICK,
    input  logic [4:0]         CUR_HOUR,
    input  logic [5:0]         CUR_MIN,
    output logic               ALM_SEL_MODE,
    output logic               ALM_ONOFF,
    output logic               ALM_HOUR,
    output logic               ALM_MIN,
    output logic [IDXW-1:0]    ALM_IDX,
    output logic               ALM_DISP_EN,
    output logic [4:0]         ALM_DISP_HOUR,
    output logic [5:0]         ALM_DISP_MIN,
    output logic [NUM_ALM-1:0] ALM_EN,
    output logic               ALM_RING,
    output logic               ALM_SNOOZING,
    output logic [IDXW-1:0]    RING_IDX
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEL    = 3'd1;
    localparam logic [2:0] ST_ONOFF  = 3'd2;
    localparam logic [2:0] ST_HOUR   = 3'd3;
    localparam logic [2:0] ST_MIN    = 3'd4;
    localparam logic [2:0] ST_RING   = 3'd5;
    localparam logic [2:0] ST_SNOOZE = 3'd6;

    // Snooze counter must hold MAX_SNOOZE itself.
    localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ALM - 1);

    logic [2:0]         state;
    logic [IDXW-1:0]    alm_idx;
    logic [IDXW-1:0]    ring_idx;
    logic               pending;
    logic [SCW-1:0]     snooze_cnt;
    logic [3:0]         snooze_tmr;
    logic [3:0]         ring_tmr;

    logic [NUM_ALM-1:0] en_q;
    logic [4:0]         hour_q [NUM_ALM];
    logic [5:0]         min_q  [NUM_ALM];

    logic               hit;
    logic [IDXW-1:0]    hit_idx;
    logic               f2_only;
    logic               in_edit;

    // F1 has priority, so F2 only acts when it arrives alone.
    assign f2_only = SW_F2 & ~SW_F1;
    assign in_edit = (state == ST_SEL) || (state == ST_ONOFF) ||
                     (state == ST_HOUR) || (state == ST_MIN);

    // Minute match: scan high to low so the lowest matching index is left last.
    always_comb begin
        // NOTE: defaults first so every path assigns hit/hit_idx and no latch is inferred.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALM - 1; i >= 0; i--) begin
            if (MIN_TICK && en_q[i] && (hour_q[i] == CUR_HOUR) && (min_q[i] == CUR_MIN)) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    // Mode sequencer: edit path, pending capture, ring/snooze/timeout handling.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            alm_idx    <= '0;
            ring_idx   <= '0;
            pending    <= 1'b0;
            snooze_cnt <= '0;
            snooze_tmr <= '0;
            ring_tmr   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state      <= ST_RING;
                        ring_idx   <= hit_idx;
                        snooze_cnt <= '0;
                        ring_tmr   <= '0;
                    end else if (SW_F1) begin
                        state <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (SW_F1) begin
                        state <= ST_ONOFF;
                    end else if (SW_F2) begin
                        alm_idx <= (alm_idx == LAST_IDX) ? '0 : alm_idx + IDXW'(1);
                    end
                end
                ST_ONOFF: begin
                    if (SW_F1) state <= ST_HOUR;
                end
                ST_HOUR: begin
                    if (SW_F1) state <= ST_MIN;
                end
                ST_MIN: begin
                    if (SW_F1) begin
                        // A match seen while editing rings as soon as editing ends.
                        if (pending || hit) begin
                            state      <= ST_RING;
                            pending    <= 1'b0;
                            snooze_cnt <= '0;
                            ring_tmr   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RING: begin
                    if (SW_F1) begin
                        state <= ST_IDLE;
                    end else if (SW_F2) begin
                        if (snooze_cnt < SCW'(MAX_SNOOZE)) begin
                            state      <= ST_SNOOZE;
                            snooze_tmr <= 4'(SNOOZE_MIN);
                            snooze_cnt <= snooze_cnt + SCW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (MIN_TICK) begin
                        if (ring_tmr == 4'(RING_TIMEOUT_MIN - 1)) state <= ST_IDLE;
                        ring_tmr <= ring_tmr + 4'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (SW_F1) begin
                        state <= ST_IDLE;
                    end else if (MIN_TICK) begin
                        if (snooze_tmr == 4'd1) begin
                            state    <= ST_RING;
                            ring_tmr <= '0;
                        end
                        snooze_tmr <= snooze_tmr - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Match during editing is remembered; the F1 that leaves MIN consumes it above.
            if (in_edit && hit) begin
                ring_idx <= hit_idx;
                if (!((state == ST_MIN) && SW_F1)) pending <= 1'b1;
            end
        end
    end

    // Alarm entry storage, edited by F2 in the ONOFF/HOUR/MIN states.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the entry array is reset because a cleared alarm bank is visible behaviour.
            en_q <= '0;
            for (int i = 0; i < NUM_ALM; i++) begin
                hour_q[i] <= '0;
                min_q[i]  <= '0;
            end
        end else if (f2_only) begin
            case (state)
                ST_ONOFF: en_q[alm_idx] <= ~en_q[alm_idx];
                ST_HOUR:  hour_q[alm_idx] <= (hour_q[alm_idx] == 5'd23) ? 5'd0
                                                                        : hour_q[alm_idx] + 5'd1;
                ST_MIN:   min_q[alm_idx]  <= (min_q[alm_idx] == 6'd59) ? 6'd0
                                                                       : min_q[alm_idx] + 6'd1;
                default:  ;
            endcase
        end
    end

    assign ALM_SEL_MODE  = (state == ST_SEL);
    assign ALM_ONOFF     = (state == ST_ONOFF);
    assign ALM_HOUR      = (state == ST_HOUR);
    assign ALM_MIN       = (state == ST_MIN);
    assign ALM_RING      = (state == ST_RING);
    assign ALM_SNOOZING  = (state == ST_SNOOZE);
    assign ALM_IDX       = alm_idx;
    assign RING_IDX      = ring_idx;
    assign ALM_EN        = en_q;
    assign ALM_DISP_EN   = en_q[alm_idx];
    assign ALM_DISP_HOUR = hour_q[alm_idx];
    assign ALM_DISP_MIN  = min_q[alm_idx];

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// tb_alarm_bank_ctrl
// Scoreboarded bench: each driven cycle advances a behavioural alarm-clock
// model and queues the expected outputs; a monitor pops and compares after
// every rising edge. Directed scenarios are followed by random stimulus.
module tb_alarm_bank_ctrl;

    localparam int NUM_ALM          = 2;
    localparam int IDXW             = 1;
    localparam int SNOOZE_MIN       = 5;
    localparam int MAX_SNOOZE       = 3;
    localparam int RING_TIMEOUT_MIN = 2;

    logic               CLK = 1'b0;
    logic               RST;
    logic               SW_F1, SW_F2, MIN_TICK;
    logic [4:0]         CUR_HOUR;
    logic [5:0]         CUR_MIN;
    logic               ALM_SEL_MODE, ALM_ONOFF, ALM_HOUR, ALM_MIN;
    logic [IDXW-1:0]    ALM_IDX;
    logic               ALM_DISP_EN;
    logic [4:0]         ALM_DISP_HOUR;
    logic [5:0]         ALM_DISP_MIN;
    logic [NUM_ALM-1:0] ALM_EN;
    logic               ALM_RING, ALM_SNOOZING;
    logic [IDXW-1:0]    RING_IDX;

    alarm_bank_ctrl #(
        .NUM_ALM(NUM_ALM), .IDXW(IDXW), .SNOOZE_MIN(SNOOZE_MIN),
        .MAX_SNOOZE(MAX_SNOOZE), .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN)
    ) dut (
        .CLK(CLK), .RST(RST), .SW_F1(SW_F1), .SW_F2(SW_F2), .MIN_TICK(MIN_TICK),
        .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN),
        .ALM_SEL_MODE(ALM_SEL_MODE), .ALM_ONOFF(ALM_ONOFF), .ALM_HOUR(ALM_HOUR),
        .ALM_MIN(ALM_MIN), .ALM_IDX(ALM_IDX), .ALM_DISP_EN(ALM_DISP_EN),
        .ALM_DISP_HOUR(ALM_DISP_HOUR), .ALM_DISP_MIN(ALM_DISP_MIN), .ALM_EN(ALM_EN),
        .ALM_RING(ALM_RING), .ALM_SNOOZING(ALM_SNOOZING), .RING_IDX(RING_IDX)
    );

    always #5 CLK = ~CLK;

    typedef enum int {M_IDLE, M_SEL, M_ONOFF, M_HOUR, M_MIN, M_RING, M_SNOOZE} mode_t;

    typedef struct {
        int sel, onoff, hr, mn, idx, disp_en, disp_hour, disp_min, en, ring, snoozing, ring_idx;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the alarm clock as the user sees it.
    mode_t m_mode;
    int    m_en [NUM_ALM];
    int    m_hour [NUM_ALM];
    int    m_min [NUM_ALM];
    int    m_idx, m_ring_idx, m_pending, m_snz_cnt, m_snz_left, m_ring_age;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE;
        for (int i = 0; i < NUM_ALM; i++) begin
            m_en[i] = 0; m_hour[i] = 0; m_min[i] = 0;
        end
        m_idx = 0; m_ring_idx = 0; m_pending = 0;
        m_snz_cnt = 0; m_snz_left = 0; m_ring_age = 0;
    endfunction

    function automatic void start_ring();
        m_mode = M_RING; m_snz_cnt = 0; m_ring_age = 0;
    endfunction

    function automatic void model_step(input bit rst_n, input bit f1, input bit f2,
                                       input bit tick, input int h, input int m);
        int    hit;
        mode_t old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hit = -1;
        if (tick)
            for (int i = 0; i < NUM_ALM; i++)
                if (hit < 0 && m_en[i] != 0 && m_hour[i] == h && m_min[i] == m) hit = i;
        old = m_mode;
        if ((old inside {M_SEL, M_ONOFF, M_HOUR, M_MIN}) && hit >= 0) begin
            m_pending = 1; m_ring_idx = hit;
        end
        if (old == M_IDLE && hit >= 0) begin
            m_ring_idx = hit;
            start_ring();
        end else if (f1) begin
            case (old)
                M_IDLE:  m_mode = M_SEL;
                M_SEL:   m_mode = M_ONOFF;
                M_ONOFF: m_mode = M_HOUR;
                M_HOUR:  m_mode = M_MIN;
                M_MIN: begin
                    if (m_pending != 0) begin
                        m_pending = 0;
                        start_ring();
                    end else m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end else if (f2) begin
            case (old)
                M_SEL:   m_idx = (m_idx + 1) % NUM_ALM;
                M_ONOFF: m_en[m_idx] = 1 - m_en[m_idx];
                M_HOUR:  m_hour[m_idx] = (m_hour[m_idx] + 1) % 24;
                M_MIN:   m_min[m_idx] = (m_min[m_idx] + 1) % 60;
                M_RING: begin
                    if (m_snz_cnt < MAX_SNOOZE) begin
                        m_mode = M_SNOOZE; m_snz_left = SNOOZE_MIN; m_snz_cnt++;
                    end else m_mode = M_IDLE;
                end
                default: ;
            endcase
        end else if (tick) begin
            if (old == M_RING) begin
                m_ring_age++;
                if (m_ring_age >= RING_TIMEOUT_MIN) m_mode = M_IDLE;
            end else if (old == M_SNOOZE) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_mode = M_RING; m_ring_age = 0;
                end
            end
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.sel       = (m_mode == M_SEL)    ? 1 : 0;
        e.onoff     = (m_mode == M_ONOFF)  ? 1 : 0;
        e.hr        = (m_mode == M_HOUR)   ? 1 : 0;
        e.mn        = (m_mode == M_MIN)    ? 1 : 0;
        e.ring      = (m_mode == M_RING)   ? 1 : 0;
        e.snoozing  = (m_mode == M_SNOOZE) ? 1 : 0;
        e.idx       = m_idx;
        e.disp_en   = m_en[m_idx];
        e.disp_hour = m_hour[m_idx];
        e.disp_min  = m_min[m_idx];
        e.ring_idx  = m_ring_idx;
        e.en        = 0;
        for (int i = 0; i < NUM_ALM; i++) if (m_en[i] != 0) e.en |= (1 << i);
        return e;
    endfunction

    // Monitor: one expected record per rising edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel_mode",  32'(ALM_SEL_MODE),  e.sel);
                check("onoff",     32'(ALM_ONOFF),     e.onoff);
                check("hour_mode", 32'(ALM_HOUR),      e.hr);
                check("min_mode",  32'(ALM_MIN),       e.mn);
                check("alm_idx",   32'(ALM_IDX),       e.idx);
                check("disp_en",   32'(ALM_DISP_EN),   e.disp_en);
                check("disp_hour", 32'(ALM_DISP_HOUR), e.disp_hour);
                check("disp_min",  32'(ALM_DISP_MIN),  e.disp_min);
                check("alm_en",    32'(ALM_EN),        e.en);
                check("ring",      32'(ALM_RING),      e.ring);
                check("snoozing",  32'(ALM_SNOOZING),  e.snoozing);
                check("ring_idx",  32'(RING_IDX),      e.ring_idx);
            end
        end
    end

    // One clock of stimulus: drive at the falling edge, queue the expectation,
    // drop the pulses after the rising edge.
    task automatic cyc(input bit rst_n, input bit f1, input bit f2, input bit tick,
                       input int h, input int m);
        @(negedge CLK);
        RST = rst_n; SW_F1 = f1; SW_F2 = f2; MIN_TICK = tick;
        CUR_HOUR = 5'(h); CUR_MIN = 6'(m);
        model_step(rst_n, f1, f2, tick, h, m);
        exp_q.push_back(snapshot());
        @(posedge CLK);
        #2;
        SW_F1 = 1'b0; SW_F2 = 1'b0; MIN_TICK = 1'b0;
    endtask

    task automatic p_f1();                       cyc(1, 1, 0, 0, 0, 0); endtask
    task automatic p_f2(input int n);            repeat (n) cyc(1, 0, 1, 0, 0, 0); endtask
    task automatic p_tick(input int h, input int m); cyc(1, 0, 0, 1, h, m); endtask

    task automatic edit_entry(input int n_sel, input int n_tog, input int n_hour, input int n_min);
        p_f1(); p_f2(n_sel);
        p_f1(); p_f2(n_tog);
        p_f1(); p_f2(n_hour);
        p_f1(); p_f2(n_min);
        p_f1();
    endtask

    initial begin
        RST = 1'b0; SW_F1 = 1'b0; SW_F2 = 1'b0; MIN_TICK = 1'b0;
        CUR_HOUR = '0; CUR_MIN = '0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Index wrap and enable toggle.
        p_f1();
        p_f2(1); check("idx_step1", 32'(ALM_IDX), 1);
        p_f2(1); check("idx_step2", 32'(ALM_IDX), 0);
        p_f2(1); check("idx_step3", 32'(ALM_IDX), 1);
        p_f1(); p_f2(1);
        check("en_after_toggle", 32'(ALM_EN), 32'h2);

        // Reset while in HOUR edit.
        p_f1();
        check("in_hour_edit", 32'(ALM_HOUR), 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_mid_hour_mode", 32'(ALM_HOUR), 0);
        check("rst_mid_en", 32'(ALM_EN), 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Hour/minute wrap and simultaneous switches.
        p_f1(); p_f1(); p_f1();
        p_f2(25); check("hour_wrap", 32'(ALM_DISP_HOUR), 1);
        cyc(1, 1, 1, 0, 0, 0);
        check("both_sw_to_min", 32'(ALM_MIN), 1);
        check("both_sw_hour_kept", 32'(ALM_DISP_HOUR), 1);
        p_f2(61); check("min_wrap", 32'(ALM_DISP_MIN), 1);
        p_f1();

        // Both entries enabled at 07:30.
        edit_entry(0, 1, 6, 29);
        edit_entry(1, 1, 7, 30);
        check("both_enabled", 32'(ALM_EN), 32'h3);
        p_tick(7, 31); check("no_ring_0731", 32'(ALM_RING), 0);
        p_tick(7, 30); check("ring_0730", 32'(ALM_RING), 1);
        check("ring_idx_low_wins", 32'(RING_IDX), 0);
        p_f1(); check("f1_dismiss", 32'(ALM_RING), 0);

        // Entry 0 disabled: entry 1 rings.
        edit_entry(1, 1, 0, 0);
        p_tick(7, 30); check("ring_idx_entry1", 32'(RING_IDX), 1);

        // Three snoozes, then the fourth F2 dismisses.
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            p_f2(1); check("snooze_entered", 32'(ALM_SNOOZING), 1);
            for (int t = 0; t < SNOOZE_MIN - 1; t++) p_tick(8, t);
            check("snooze_held", 32'(ALM_SNOOZING), 1);
            p_tick(8, 10); check("snooze_rerings", 32'(ALM_RING), 1);
        end
        p_f2(1);
        check("snooze_exhausted_ring", 32'(ALM_RING), 0);
        check("snooze_exhausted_snz", 32'(ALM_SNOOZING), 0);

        // Unanswered ring times out.
        p_tick(7, 30);
        p_tick(8, 1); check("timeout_still_ringing", 32'(ALM_RING), 1);
        p_tick(8, 2); check("timeout_dismiss", 32'(ALM_RING), 0);
        p_tick(7, 30); p_f1(); check("f1_in_ring", 32'(ALM_RING), 0);

        // Match during editing is deferred to the end of editing.
        p_f1(); p_f1(); p_f1();
        p_tick(7, 30); check("no_ring_while_edit", 32'(ALM_RING), 0);
        p_f1(); p_f1();
        check("pending_ring", 32'(ALM_RING), 1);
        check("pending_ring_idx", 32'(RING_IDX), 1);
        p_f1();

        // Random stimulus; ticks never coincide with switch pulses.
        for (int n = 0; n < 1500; n++) begin
            int r, h, m, k;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, NUM_ALM - 1);
                h = m_hour[k]; m = m_min[k];
            end else begin
                h = $urandom_range(0, 23); m = $urandom_range(0, 59);
            end
            if (r < 10)      cyc(1, 1, 0, 0, 0, 0);
            else if (r < 30) cyc(1, 0, 1, 0, 0, 0);
            else if (r < 33) cyc(1, 1, 1, 0, 0, 0);
            else if (r < 50) cyc(1, 0, 0, 1, h, m);
            else if (r == 99 && $urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 0, 0);
            else             cyc(1, 0, 0, 0, 0, 0);
        end

        cyc(1, 0, 0, 0, 0, 0);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
